skewed_systolic_array: RTL and testbench

//  Self-sequencing output-stationary GEMM tile: C[r][c] = sum_k W[r][k]*A[k][c] over a job of K beats.

---
 rtl/skewed_systolic_array.sv | 215 +++++++++++++++++++++
 tb/tb_skewed_systolic_array.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skewed_systolic_array.sv
// rtl/skewed_systolic_array.sv - self-sequencing output-stationary GEMM tile with input skew and row-serial drain
// Optional feature macro: SKEWED_SA_SATURATE_EN (saturating accumulate + sticky sat_flag).
module skewed_systolic_array #(
  parameter int IN_N = 8,
  parameter int ACC_N = 32,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [ROWS*IN_N-1:0]    weights_in,
  input  logic [COLS*IN_N-1:0]    acts_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_N-1:0]   out_row,
  output logic [IDX_W-1:0]        out_row_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    sat_flag
);
  localparam int CNT_W = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic accept, out_hs, job_done;

  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign job_done = out_hs && out_last;

  logic signed [IN_N-1:0] w_skew [ROWS];
  logic signed [IN_N-1:0] a_skew [COLS];
  logic w_skew_v [ROWS];
  logic a_skew_v [COLS];
  logic [ROWS-1:0] w_lane_busy;
  logic [COLS-1:0] a_lane_busy;

  // Lane r holds r+1 registers: one capture stage plus r skew stages.
  for (genvar r = 0; r < ROWS; r++) begin : g_wskew
    logic signed [IN_N-1:0] d [r+1];
    logic [r:0] v;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= r; j++) d[j] <= '0;
        v <= '0;
      end else begin
        d[0] <= weights_in[r*IN_N +: IN_N];
        v[0] <= accept;
        for (int j = 1; j <= r; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
        end
      end
    end
    assign w_skew[r]      = d[r];
    assign w_skew_v[r]    = v[r];
    assign w_lane_busy[r] = |v;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_askew
    logic signed [IN_N-1:0] d [c+1];
    logic [c:0] v;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= c; j++) d[j] <= '0;
        v <= '0;
      end else begin
        d[0] <= acts_in[c*IN_N +: IN_N];
        v[0] <= accept;
        for (int j = 1; j <= c; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
        end
      end
    end
    assign a_skew[c]      = d[c];
    assign a_skew_v[c]    = v[c];
    assign a_lane_busy[c] = |v;
  end

  logic signed [IN_N-1:0] w_q [ROWS][COLS];
  logic signed [IN_N-1:0] a_q [ROWS][COLS];
  logic wv_q [ROWS][COLS];
  logic av_q [ROWS][COLS];
  logic signed [ACC_N-1:0] acc [ROWS][COLS];
  logic [ROWS*COLS-1:0] pe_busy;
`ifdef SKEWED_SA_SATURATE_EN
  logic [ROWS*COLS-1:0] clip;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [IN_N-1:0] w_in, a_in, w_r, a_r;
      logic wv_in, av_in, wv_r, av_r;
      logic signed [2*IN_N-1:0] prod;
      logic signed [ACC_N-1:0] prod_x, acc_r, acc_nxt;

      if (c == 0) begin : g_wl
        assign w_in  = w_skew[r];
        assign wv_in = w_skew_v[r];
      end else begin : g_wg
        assign w_in  = w_q[r][c-1];
        assign wv_in = wv_q[r][c-1];
      end
      if (r == 0) begin : g_al
        assign a_in  = a_skew[c];
        assign av_in = a_skew_v[c];
      end else begin : g_ag
        assign a_in  = a_q[r-1][c];
        assign av_in = av_q[r-1][c];
      end

      assign prod   = w_in * a_in;
      assign prod_x = ACC_N'(prod);

`ifdef SKEWED_SA_SATURATE_EN
      logic [ACC_N:0] sum;
      logic clip_now;
      assign sum = {acc_r[ACC_N-1], acc_r} + {prod_x[ACC_N-1], prod_x};
      always_comb begin
        clip_now = sum[ACC_N] != sum[ACC_N-1];
        if (!clip_now)       acc_nxt = sum[ACC_N-1:0];
        else if (sum[ACC_N]) acc_nxt = {1'b1, {(ACC_N-1){1'b0}}};
        else                 acc_nxt = {1'b0, {(ACC_N-1){1'b1}}};
      end
      assign clip[r*COLS+c] = clip_now && wv_in && av_in;
`else
      assign acc_nxt = acc_r + prod_x;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          w_r   <= '0;
          a_r   <= '0;
          wv_r  <= 1'b0;
          av_r  <= 1'b0;
          acc_r <= '0;
        end else begin
          w_r  <= w_in;
          a_r  <= a_in;
          wv_r <= wv_in;
          av_r <= av_in;
          if (job_done)           acc_r <= '0;
          else if (wv_in && av_in) acc_r <= acc_nxt;
        end
      end

      assign w_q[r][c]  = w_r;
      assign a_q[r][c]  = a_r;
      assign wv_q[r][c] = wv_r;
      assign av_q[r][c] = av_r;
      assign acc[r][c]  = acc_r;
      assign pe_busy[r*COLS+c] = wv_r | av_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACCUM && accept && in_last) cnt <= CNT_W'(ROWS + COLS - 2);
      else if (state == FLUSH && cnt != '0)    cnt <= cnt - 1'b1;
      if (out_hs) idx <= out_last ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = FLUSH;
      end
      FLUSH: if (cnt == '0) state_nxt = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && idx == IDX_W'(ROWS - 1)) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    out_row = '0;
    if (out_valid)
      for (int c = 0; c < COLS; c++) out_row[c*ACC_N +: ACC_N] = acc[idx][c];
  end

  assign out_row_idx = idx;
  assign out_last    = out_valid && (idx == IDX_W'(ROWS - 1));
  assign busy        = (state != ACCUM) || (|pe_busy) || (|w_lane_busy) || (|a_lane_busy);

`ifdef SKEWED_SA_SATURATE_EN
  logic sat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sat_q <= 1'b0;
    else if (job_done) sat_q <= 1'b0;
    else if (|clip)    sat_q <= 1'b1;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_skewed_systolic_array.sv
// tb/tb_skewed_systolic_array.sv - randomized GEMM-model bench for skewed_systolic_array (8x8 and 2x2/ACC16 instances)
module tb_skewed_systolic_array;
  localparam int R = 8, C = 8, N = 8, AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy, sat_flag;
  logic [R*N-1:0] weights_in;
  logic [C*N-1:0] acts_in;
  logic [C*AW-1:0] out_row;
  logic [2:0] out_row_idx;

  logic s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_last, s_busy, s_sat;
  logic [15:0] s_w, s_a;
  logic [31:0] s_out_row;
  logic s_idx;

  int checks = 0;
  int failures = 0;
  int jw [R][64];
  int ja [64][C];
  longint gold [R][C];
  int sw [2][4];
  int sa [4][2];
  int sexp [2][2];

  skewed_systolic_array #(.IN_N(N), .ACC_N(AW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .weights_in(weights_in), .acts_in(acts_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .sat_flag(sat_flag));

  skewed_systolic_array #(.IN_N(8), .ACC_N(16), .ROWS(2), .COLS(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(s_in_last),
    .weights_in(s_w), .acts_in(s_a), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_row(s_out_row), .out_row_idx(s_idx), .out_last(s_out_last), .busy(s_busy), .sat_flag(s_sat));

  task automatic compute_gold(input int k);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        gold[r][c] = 0;
        for (int b = 0; b < k; b++) gold[r][c] += longint'(jw[r][b]) * longint'(ja[b][c]);
      end
  endtask

  task automatic random_job(input int k);
    for (int b = 0; b < k; b++) begin
      for (int r = 0; r < R; r++) jw[r][b] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < C; c++) ja[b][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic send_job(input int k, input int max_gap);
    int n;
    for (int b = 0; b < k; b++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      for (int r = 0; r < R; r++) weights_in[r*N +: N] = jw[r][b][7:0];
      for (int c = 0; c < C; c++) acts_in[c*N +: N] = ja[b][c][7:0];
      in_valid = 1'b1;
      in_last = (b == k - 1);
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) begin
        failures++;
        $display("FAIL send_timeout beat=%0d in_ready=%b required=1", b, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain_check(input string tag, input bit rnd);
    int row, guard;
    bit stall;
    logic [C*AW-1:0] held, exp;
    logic [2:0] held_idx, exp_idx;
    row = 0; guard = 0; stall = 0; held = '0; held_idx = '0;
    while (row < R && guard < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        for (int c = 0; c < C; c++) exp[c*AW +: AW] = gold[row][c][AW-1:0];
        exp_idx = row[2:0];
        checks++;
        if (out_row !== exp || out_row_idx !== exp_idx) begin
          failures++;
          $display("FAIL %s_row idx=%0d row=%h required idx=%0d row=%h", tag, out_row_idx, out_row, exp_idx, exp);
        end
        checks++;
        if (out_last !== (row == R - 1)) begin
          failures++;
          $display("FAIL %s_last row=%0d out_last=%b", tag, row, out_last);
        end
        if (stall) begin
          checks++;
          if (out_row !== held || out_row_idx !== held_idx) begin
            failures++;
            $display("FAIL %s_stall_stable idx=%0d row=%h required idx=%0d row=%h", tag, out_row_idx, out_row, held_idx, held);
          end
        end
        held = out_row;
        held_idx = out_row_idx;
        stall = !out_ready;
        if (out_ready) row++;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    checks++;
    if (row != R) begin
      failures++;
      $display("FAIL %s_drain_timeout rows=%0d required=%0d", tag, row, R);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || sat_flag !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_job in_ready=%b busy=%b sat=%b out_valid=%b required 1 0 0 0", tag, in_ready, busy, sat_flag, out_valid);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_row !== '0 || out_row_idx !== 3'd0 ||
        out_last !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b row=%h idx=%0d last=%b busy=%b sat=%b",
               in_ready, out_valid, out_row, out_row_idx, out_last, busy, sat_flag);
    end
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_row !== '0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_small in_ready=%b out_valid=%b row=%h busy=%b", s_in_ready, s_out_valid, s_out_row, s_busy);
    end
  endtask

  task automatic test_latency;
    int cyc;
    for (int r = 0; r < R; r++) jw[r][0] = 2;
    for (int c = 0; c < C; c++) ja[0][c] = 3;
    compute_gold(1);
    send_job(1, 0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_flags in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc != R + C - 1) begin
      failures++;
      $display("FAIL first_valid_latency cycles=%0d required=%0d", cyc, R + C - 1);
    end
    drain_check("latency", 1'b0);
  endtask

  task automatic test_extremes;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < R; r++) jw[r][b] = -128;
      for (int c = 0; c < C; c++) ja[b][c] = (c % 2 == 0) ? -128 : 127;
    end
    compute_gold(4);
    send_job(4, 1);
    drain_check("extremes", 1'b0);
  endtask

  task automatic test_back_to_back;
    random_job(16);
    compute_gold(16);
    send_job(16, 3);
    drain_check("job1", 1'b1);
    random_job(16);
    compute_gold(16);
    send_job(16, 2);
    drain_check("job2", 1'b1);
  endtask

  task automatic test_reset_flush;
    random_job(5);
    send_job(5, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_flush out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    random_job(6);
    compute_gold(6);
    send_job(6, 2);
    drain_check("post_reset", 1'b1);
  endtask

  task automatic s_run(input int k, input bit exp_sat, input string tag);
    int n, row;
    for (int b = 0; b < k; b++) begin
      s_w = {sw[1][b][7:0], sw[0][b][7:0]};
      s_a = {sa[b][1][7:0], sa[b][0][7:0]};
      s_in_valid = 1'b1;
      s_in_last = (b == k - 1);
      n = 0;
      while (!s_in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    s_in_last = 1'b0;
    s_out_ready = 1'b1;
    row = 0; n = 0;
    while (row < 2 && n < 100) begin
      if (s_out_valid) begin
        checks++;
        if (s_out_row[15:0] !== 16'(sexp[row][0]) || s_out_row[31:16] !== 16'(sexp[row][1]) ||
            s_idx !== row[0] || s_out_last !== (row == 1)) begin
          failures++;
          $display("FAIL %s_row%0d row=%h idx=%0d last=%b required row=%h%h", tag, row, s_out_row, s_idx,
                   s_out_last, 16'(sexp[row][1]), 16'(sexp[row][0]));
        end
        checks++;
        if (s_sat !== exp_sat) begin
          failures++;
          $display("FAIL %s_sat sat=%b required=%b", tag, s_sat, exp_sat);
        end
        row++;
      end
      @(posedge clk); #1;
      n++;
    end
    s_out_ready = 1'b0;
    checks++;
    if (row != 2 || s_sat !== 1'b0 || s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_end rows=%0d sat=%b in_ready=%b required 2 0 1", tag, row, s_sat, s_in_ready);
    end
  endtask

  task automatic test_small_identity;
    sw[0][0] = 1; sw[1][0] = 0; sw[0][1] = 0; sw[1][1] = 1;
    sa[0][0] = 3; sa[0][1] = 4; sa[1][0] = 5; sa[1][1] = 6;
    sexp[0][0] = 3; sexp[0][1] = 4; sexp[1][0] = 5; sexp[1][1] = 6;
    s_run(2, 1'b0, "identity");
  endtask

  task automatic test_small_overflow;
    int e;
    bit es;
`ifdef SKEWED_SA_SATURATE_EN
    e = 32767; es = 1'b1;
`else
    e = 3 * 127 * 127 - 65536; es = 1'b0;
`endif
    for (int b = 0; b < 3; b++) begin
      sw[0][b] = 127; sw[1][b] = 127; sa[b][0] = 127; sa[b][1] = 127;
    end
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) sexp[r][c] = e;
    s_run(3, es, "overflow");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; weights_in = '0; acts_in = '0;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b0; s_w = '0; s_a = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_latency;
    test_extremes;
    test_back_to_back;
    test_small_identity;
    test_small_overflow;
    test_reset_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
